// File: rtl/sha256_block_server.sv
// Message-block buffer for a SHA-256 core: host loads 64 bytes, the core fetches
// 16 big-endian words through an rq/rdy handshake, word 3 optionally replaced by a nonce.
module sha256_block_server #(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [7:0]  wr_byte,
    input  logic        clr,
    output logic        full,
    input  logic        nonce_en,
    input  logic        nonce_ld,
    input  logic [31:0] nonce_in,
    input  logic        nonce_inc,
    output logic [31:0] nonce,
    input  logic        rq,
    input  logic [3:0]  addr,
    output logic [31:0] data,
    output logic        rdy,
    output logic        block_done
);

    localparam logic [2:0] LAT3 = 3'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        REL  = 2'd3
    } state_t;

    // Host byte loader
    logic [5:0]  ptr_q, ptr_d;
    logic        full_q, full_d;
    logic        wr_fire;
    logic [31:0] nonce_q, nonce_d;

    assign wr_fire = wr_en && !full_q && !clr;

    always_comb begin
        ptr_d  = ptr_q;
        full_d = full_q;
        if (clr) begin
            ptr_d  = 6'd0;
            full_d = 1'b0;
        end else if (wr_fire) begin
            ptr_d = ptr_q + 6'd1;
            if (ptr_q == 6'd63) begin
                full_d = 1'b1;
            end
        end
    end

    always_comb begin
        nonce_d = nonce_q;
        if (nonce_ld) begin
            nonce_d = nonce_in;
        end else if (nonce_inc) begin
            nonce_d = nonce_q + 32'd1;
        end
    end

    // Responder registers
    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        rdy_q, rdy_d;
    logic        done_q, done_d;

    // One byte-lane RAM per generate branch; byte offset 0 lands in the top lane.
    logic [3:0][7:0] rd_lanes;
    logic [31:0]     rd_word;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [16];
            always_ff @(posedge clk) begin
                if (wr_fire && (ptr_q[1:0] == 2'(3 - gi))) begin
                    lane_mem[ptr_q[5:2]] <= wr_byte;
                end
            end
            assign rd_lanes[gi] = lane_mem[addr_q];
        end
    endgenerate

    assign rd_word = rd_lanes;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdy_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rq && full_q) begin
                    addr_d  = addr;
                    cnt_d   = LAT3;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    data_d  = (addr_q == 4'd3 && nonce_en) ? nonce_q : rd_word;
                    rdy_d   = 1'b1;
                    done_d  = (addr_q == 4'd15);
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ACK: begin
                state_d = REL;
            end
            REL: begin
                // Never re-acknowledge a request that has not dropped first
                if (!rq) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= 6'd0;
            full_q  <= 1'b0;
            nonce_q <= 32'd0;
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= 4'd0;
            data_q  <= 32'd0;
            rdy_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            full_q  <= full_d;
            nonce_q <= nonce_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
        end
    end

    assign full       = full_q;
    assign nonce      = nonce_q;
    assign data       = data_q;
    assign rdy        = rdy_q;
    assign block_done = done_q;

endmodule

// File: tb/tb_sha256_block_server.sv
// Scoreboard bench for sha256_block_server: three instances (LATENCY 0/1/7) share
// the host side; each has its own rq so handshakes stay independent.
module tb_sha256_block_server;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        wr_en, clr, nonce_en, nonce_ld, nonce_inc;
    logic [7:0]  wr_byte;
    logic [31:0] nonce_in;
    logic [3:0]  addr;
    logic [2:0]  rq_v;
    logic [2:0]  rdy_v, done_v, full_v;
    logic [31:0] data_v  [3];
    logic [31:0] nonce_v [3];

    sha256_block_server #(.LATENCY(0)) u_dut_l0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_byte(wr_byte), .clr(clr),
        .full(full_v[0]), .nonce_en(nonce_en), .nonce_ld(nonce_ld),
        .nonce_in(nonce_in), .nonce_inc(nonce_inc), .nonce(nonce_v[0]),
        .rq(rq_v[0]), .addr(addr), .data(data_v[0]), .rdy(rdy_v[0]),
        .block_done(done_v[0])
    );

    sha256_block_server #(.LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_byte(wr_byte), .clr(clr),
        .full(full_v[1]), .nonce_en(nonce_en), .nonce_ld(nonce_ld),
        .nonce_in(nonce_in), .nonce_inc(nonce_inc), .nonce(nonce_v[1]),
        .rq(rq_v[1]), .addr(addr), .data(data_v[1]), .rdy(rdy_v[1]),
        .block_done(done_v[1])
    );

    sha256_block_server #(.LATENCY(7)) u_dut_l7 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_byte(wr_byte), .clr(clr),
        .full(full_v[2]), .nonce_en(nonce_en), .nonce_ld(nonce_ld),
        .nonce_in(nonce_in), .nonce_inc(nonce_inc), .nonce(nonce_v[2]),
        .rq(rq_v[2]), .addr(addr), .data(data_v[2]), .rdy(rdy_v[2]),
        .block_done(done_v[2])
    );

    // Reference model of the host side
    logic [31:0] exp_mem [16];
    int          ptr_m;
    bit          full_m;
    logic [31:0] nonce_m;
    logic [31:0] exp_q [$];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic int lat_of(input int sel);
        case (sel)
            0:       return 0;
            1:       return 1;
            default: return 7;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("[TB] ok %s: %08h", tag, got);
        end
    endtask

    task automatic wr_one(input logic [7:0] b);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_byte = b;
        if (!full_m) begin
            exp_mem[ptr_m / 4][8 * (3 - ptr_m % 4) +: 8] = b;
            ptr_m++;
            if (ptr_m == 64) full_m = 1'b1;
        end
    endtask

    task automatic end_writes();
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic load_bytes(input logic [7:0] base);
        for (int i = 0; i < 64; i++) begin
            if (i == 63) begin
                @(posedge clk);
                #1;
                check_eq("full_before_64th", {31'd0, full_v[1]}, 32'd0);
            end
            wr_one(base + 8'(i));
        end
        end_writes();
        check_eq("full_after_64th", {31'd0, full_v[1]}, {31'd0, full_m});
    endtask

    task automatic do_clr(input bit with_wr);
        @(negedge clk);
        clr     = 1'b1;
        wr_en   = with_wr;
        wr_byte = 8'hAA;
        ptr_m   = 0;
        full_m  = 1'b0;
        @(negedge clk);
        clr   = 1'b0;
        wr_en = 1'b0;
        check_eq("full_after_clr", {31'd0, full_v[1]}, 32'd0);
    endtask

    task automatic nonce_op(input bit ld, input bit inc, input logic [31:0] val);
        @(negedge clk);
        nonce_ld  = ld;
        nonce_inc = inc;
        nonce_in  = val;
        if (ld) nonce_m = val;
        else if (inc) nonce_m = nonce_m + 32'd1;
        @(negedge clk);
        nonce_ld  = 1'b0;
        nonce_inc = 1'b0;
        check_eq("nonce", nonce_v[1], nonce_m);
    endtask

    task automatic push_exp(input logic [3:0] a);
        exp_q.push_back((a == 4'd3 && nonce_en) ? nonce_m : exp_mem[a]);
    endtask

    task automatic serve_wait(input int sel, output int n);
        int i;
        i = 0;
        n = -1;
        while (n < 0 && i < 40) begin
            @(posedge clk);
            #1;
            i++;
            if (rdy_v[sel]) n = i;
        end
    endtask

    task automatic finish_ack(input int sel, input logic [3:0] a);
        logic [31:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check_eq($sformatf("data_l%0d_w%0d", lat_of(sel), a), data_v[sel], e);
        check_eq("block_done", {31'd0, done_v[sel]}, {31'd0, (a == 4'd15)});
        @(posedge clk);
        #1;
        check_eq("rdy_one_cycle", {31'd0, rdy_v[sel]}, 32'd0);
        check_eq("done_one_cycle", {31'd0, done_v[sel]}, 32'd0);
        check_eq("data_hold", data_v[sel], e);
        rq_v[sel] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int sel, input logic [3:0] a);
        int n;
        @(negedge clk);
        addr      = a;
        rq_v[sel] = 1'b1;
        push_exp(a);
        @(posedge clk);
        serve_wait(sel, n);
        check_eq($sformatf("latency_l%0d", lat_of(sel)), n, 1 + lat_of(sel));
        finish_ack(sel, a);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hits;
        rst = 1'b1;
        wr_en = 1'b0; clr = 1'b0; nonce_en = 1'b0; nonce_ld = 1'b0; nonce_inc = 1'b0;
        wr_byte = 8'd0; nonce_in = 32'd0; addr = 4'd0; rq_v = 3'b000;
        ptr_m = 0; full_m = 1'b0; nonce_m = 32'd0;
        for (int i = 0; i < 16; i++) exp_mem[i] = 32'd0;

        #12;
        check_eq("rst_rdy", {31'd0, rdy_v[1]}, 32'd0);
        check_eq("rst_data", data_v[1], 32'd0);
        check_eq("rst_done", {31'd0, done_v[1]}, 32'd0);
        check_eq("rst_full", {31'd0, full_v[1]}, 32'd0);
        check_eq("rst_nonce", nonce_v[1], 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Incrementing bytes, then a single word fetch
        load_bytes(8'h00);
        fetch(1, 4'd2);
        check_eq("word2_const", data_v[1], 32'h08090A0B);

        // Whole block in order
        for (int w = 0; w < 16; w++) fetch(1, 4'(w));

        // Nonce wrap, priority and substitution
        nonce_op(1'b1, 1'b0, 32'hFFFF_FFFF);
        nonce_op(1'b0, 1'b1, 32'd0);
        nonce_en = 1'b1;
        fetch(1, 4'd3);
        nonce_op(1'b1, 1'b1, 32'h1234_5678);
        nonce_op(1'b0, 1'b1, 32'd0);
        fetch(1, 4'd3);
        nonce_en = 1'b0;
        fetch(1, 4'd3);

        // Latency extremes
        fetch(0, 4'd7);
        fetch(2, 4'd7);
        fetch(0, 4'd15);
        fetch(2, 4'd15);

        // Partial load, clr racing a write, request while not full
        do_clr(1'b0);
        for (int i = 0; i < 10; i++) wr_one(8'h50 + 8'(i));
        end_writes();
        do_clr(1'b1);
        @(negedge clk);
        addr    = 4'd9;
        rq_v[1] = 1'b1;
        hits = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (rdy_v[1]) hits++;
        end
        check_eq("no_rdy_when_empty", hits, 0);
        load_bytes(8'h80);
        push_exp(4'd9);
        serve_wait(1, n);
        check_eq("latency_after_fill", n, 2 + lat_of(1));
        finish_ack(1, 4'd9);

        // 65th byte must not land anywhere
        wr_one(8'hFF);
        end_writes();
        check_eq("full_after_65th", {31'd0, full_v[1]}, 32'd1);
        fetch(1, 4'd0);

        // Reset while the slow instance sits in WAIT
        @(negedge clk);
        addr    = 4'd5;
        rq_v[2] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        ptr_m = 0; full_m = 1'b0; nonce_m = 32'd0;
        check_eq("midrst_rdy", {31'd0, rdy_v[2]}, 32'd0);
        check_eq("midrst_data", data_v[2], 32'd0);
        check_eq("midrst_full", {31'd0, full_v[2]}, 32'd0);
        check_eq("midrst_nonce", nonce_v[2], 32'd0);
        check_eq("midrst_done", {31'd0, done_v[2]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (rdy_v[2]) hits++;
        end
        check_eq("no_rdy_after_rst", hits, 0);
        load_bytes(8'h40);
        push_exp(4'd5);
        serve_wait(2, n);
        check_eq("latency_held_rq", n, 2 + lat_of(2));
        finish_ack(2, 4'd5);
        fetch(1, 4'd15);
        fetch(1, 4'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
